// File: rtl/demux_n_out.sv
// demux_n_out: 1-to-N valid/ready demultiplexer with a one-word holding
// register per channel. Words addressed to non-existent channels are
// discarded and counted in a saturating drop counter.
module demux_n_out #(
    parameter int DATA_W        = 10,
    parameter int N_OUT         = 4,
    parameter int SEL_W         = $clog2(N_OUT),
    parameter int SEL_FROM_DATA = 0,
    parameter int DROP_W        = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic [SEL_W-1:0]        select_i,
    output logic                    in_ready_o,
    output logic [N_OUT*DATA_W-1:0] out_data_o,
    output logic [N_OUT-1:0]        out_valid_o,
    input  logic [N_OUT-1:0]        out_ready_i,
    output logic [DROP_W-1:0]       drop_count_o
);

    logic [SEL_W-1:0]  dest;
    logic [N_OUT-1:0]  hit;
    logic              in_range;
    logic              accept;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    // Destination comes either from the select port or from the class bits
    // at the top of the word.
    generate
        if (SEL_FROM_DATA != 0) begin : g_sel_data
            logic unused_select;
            assign unused_select = ^select_i;
            assign dest = in_data_i[DATA_W-1 -: SEL_W];
        end else begin : g_sel_port
            assign dest = select_i;
        end
    endgenerate

    // One-hot channel match; an out-of-range destination matches nothing.
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit[k] = (dest == SEL_W'(k));
        end
    end

    assign in_range = |hit;

    // Ready unless the target channel is full and not draining this cycle.
    // Out-of-range words are always taken so they can be discarded.
    assign in_ready_o = ~|(hit & out_valid_o & ~out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_ch
            logic [DATA_W-1:0] data_q;
            logic              valid_q;

            // Holding register: push wins over pop, so push+pop streams.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (accept && hit[k]) begin
                    data_q  <= in_data_i;
                    valid_q <= 1'b1;
                end else if (valid_q && out_ready_i[k]) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_data_o[k*DATA_W +: DATA_W] = data_q;
            assign out_valid_o[k]                 = valid_q;
        end
    endgenerate

    // Saturating increment on every discarded word.
    always_comb begin
        drop_d = drop_q;
        if (accept && !in_range && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_demux_n_out.sv
// Self-checking bench for demux_n_out: three instances cover the default
// select-port build, a non-power-of-two build with a narrow drop counter,
// and the data-class routing build.
module tb_demux_n_out;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: DATA_W=10, N_OUT=4, select port
    logic        a_rst_n, a_vld, a_rdy;
    logic [9:0]  a_d;
    logic [1:0]  a_sel;
    logic [39:0] a_od;
    logic [3:0]  a_ov, a_ordy;
    logic [7:0]  a_dc;

    demux_n_out #(.DATA_W(10), .N_OUT(4), .SEL_FROM_DATA(0), .DROP_W(8)) u_a (
        .clk_i(clk), .rst_ni(a_rst_n), .in_valid_i(a_vld), .in_data_i(a_d),
        .select_i(a_sel), .in_ready_o(a_rdy), .out_data_o(a_od),
        .out_valid_o(a_ov), .out_ready_i(a_ordy), .drop_count_o(a_dc));

    // Instance B: N_OUT=3, DROP_W=2
    logic        b_rst_n, b_vld, b_rdy;
    logic [9:0]  b_d;
    logic [1:0]  b_sel;
    logic [29:0] b_od;
    logic [2:0]  b_ov, b_ordy;
    logic [1:0]  b_dc;

    demux_n_out #(.DATA_W(10), .N_OUT(3), .SEL_FROM_DATA(0), .DROP_W(2)) u_b (
        .clk_i(clk), .rst_ni(b_rst_n), .in_valid_i(b_vld), .in_data_i(b_d),
        .select_i(b_sel), .in_ready_o(b_rdy), .out_data_o(b_od),
        .out_valid_o(b_ov), .out_ready_i(b_ordy), .drop_count_o(b_dc));

    // Instance C: SEL_FROM_DATA=1, N_OUT=4
    logic        c_rst_n, c_vld, c_rdy;
    logic [9:0]  c_d;
    logic [1:0]  c_sel;
    logic [39:0] c_od;
    logic [3:0]  c_ov, c_ordy;
    logic [7:0]  c_dc;

    demux_n_out #(.DATA_W(10), .N_OUT(4), .SEL_FROM_DATA(1), .DROP_W(8)) u_c (
        .clk_i(clk), .rst_ni(c_rst_n), .in_valid_i(c_vld), .in_data_i(c_d),
        .select_i(c_sel), .in_ready_o(c_rdy), .out_data_o(c_od),
        .out_valid_o(c_ov), .out_ready_i(c_ordy), .drop_count_o(c_dc));

    typedef struct {
        logic        vld;
        logic [9:0]  d;
        logic [1:0]  sel;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [39:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic [9:0] d,
                                input logic [1:0] sel, input logic [3:0] ordy,
                                input logic exp_rdy, input logic [3:0] exp_ov,
                                input logic [39:0] exp_od);
        vec_t v;
        v.vld = vld; v.d = d; v.sel = sel; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_od = exp_od;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_drop;

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        a_vld = 1'b0; a_d = '0; a_sel = '0; a_ordy = '0;
        b_vld = 1'b0; b_d = '0; b_sel = '0; b_ordy = '0;
        c_vld = 1'b0; c_d = '0; c_sel = '0; c_ordy = '0;

        // Routing table for instance A, channels packed {ch3,ch2,ch1,ch0}
        vecs.push_back(mk(1, 10'h155, 2, 4'b0000, 1, 4'b0100, {10'h000, 10'h155, 10'h000, 10'h000}));
        vecs.push_back(mk(1, 10'h0AA, 2, 4'b0000, 0, 4'b0100, {10'h000, 10'h155, 10'h000, 10'h000}));
        vecs.push_back(mk(1, 10'h0AA, 2, 4'b0100, 1, 4'b0100, {10'h000, 10'h0AA, 10'h000, 10'h000}));
        vecs.push_back(mk(1, 10'h011, 0, 4'b0000, 1, 4'b0101, {10'h000, 10'h0AA, 10'h000, 10'h011}));
        vecs.push_back(mk(1, 10'h022, 1, 4'b0000, 1, 4'b0111, {10'h000, 10'h0AA, 10'h022, 10'h011}));
        vecs.push_back(mk(1, 10'h033, 3, 4'b0000, 1, 4'b1111, {10'h033, 10'h0AA, 10'h022, 10'h011}));
        vecs.push_back(mk(1, 10'h044, 0, 4'b0000, 0, 4'b1111, {10'h033, 10'h0AA, 10'h022, 10'h011}));
        vecs.push_back(mk(0, 10'h3FF, 0, 4'b1111, 1, 4'b0000, {10'h033, 10'h0AA, 10'h022, 10'h011}));
        vecs.push_back(mk(0, 10'h3FF, 2, 4'b0000, 1, 4'b0000, {10'h033, 10'h0AA, 10'h022, 10'h011}));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 10'(i), 1, 4'b0010, 1, 4'b0010,
                              {10'h033, 10'h0AA, 10'(i), 10'h011}));
        end
        vecs.push_back(mk(0, 10'h000, 1, 4'b0010, 1, 4'b0000, {10'h033, 10'h0AA, 10'h007, 10'h011}));

        // Reset state, all instances
        #12;
        chk("rst_a_ov", 64'(a_ov), 64'h0);
        chk("rst_a_od", 64'(a_od), 64'h0);
        chk("rst_a_dc", 64'(a_dc), 64'h0);
        chk("rst_a_rdy", 64'(a_rdy), 64'h1);
        chk("rst_b_ov", 64'(b_ov), 64'h0);
        chk("rst_b_dc", 64'(b_dc), 64'h0);
        chk("rst_c_ov", 64'(c_ov), 64'h0);
        chk("rst_c_rdy", 64'(c_rdy), 64'h1);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

        // Instance A: table-driven routing, back-pressure, independence, streaming
        for (int i = 0; i < vecs.size(); i++) begin
            a_vld = vecs[i].vld; a_d = vecs[i].d; a_sel = vecs[i].sel; a_ordy = vecs[i].ordy;
            #1;
            chk($sformatf("a_rdy[%0d]", i), 64'(a_rdy), 64'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("a_ov[%0d]", i), 64'(a_ov), 64'(vecs[i].exp_ov));
            chk($sformatf("a_od[%0d]", i), 64'(a_od), 64'(vecs[i].exp_od));
            chk($sformatf("a_dc[%0d]", i), 64'(a_dc), 64'h0);
        end
        a_vld = 1'b0; a_ordy = '0;

        // Instance B: out-of-range drops with saturation at 3
        exp_drop = 2'd0;
        for (int i = 0; i < 5; i++) begin
            b_vld = 1'b1; b_d = 10'(10'h100 + i); b_sel = 2'd3; b_ordy = 3'b000;
            #1;
            chk($sformatf("b_rdy[%0d]", i), 64'(b_rdy), 64'h1);
            tick();
            if (exp_drop != 2'd3) exp_drop = exp_drop + 2'd1;
            chk($sformatf("b_dc[%0d]", i), 64'(b_dc), 64'(exp_drop));
            chk($sformatf("b_ov[%0d]", i), 64'(b_ov), 64'h0);
            chk($sformatf("b_od[%0d]", i), 64'(b_od), 64'h0);
        end
        // An in-range word still routes and leaves the counter alone
        b_vld = 1'b1; b_d = 10'h2C3; b_sel = 2'd2;
        #1;
        chk("b_rdy_inrange", 64'(b_rdy), 64'h1);
        tick();
        chk("b_ov_inrange", 64'(b_ov), 64'b100);
        chk("b_od_inrange", 64'(b_od), 64'({10'h2C3, 10'h000, 10'h000}));
        chk("b_dc_inrange", 64'(b_dc), 64'd3);
        b_vld = 1'b0;

        // Instance C: class bits route to channel 3, select port ignored
        c_vld = 1'b1; c_d = 10'b11_0000_0001; c_sel = 2'd0; c_ordy = 4'b0000;
        #1;
        chk("c_rdy", 64'(c_rdy), 64'h1);
        tick();
        c_vld = 1'b0;
        chk("c_ov", 64'(c_ov), 64'b1000);
        chk("c_od", 64'(c_od), 64'({10'h301, 10'h000, 10'h000, 10'h000}));
        // Class 3 full and stalled: back-pressure even though select_i=0
        c_vld = 1'b1; c_d = 10'b11_0000_0010;
        #1;
        chk("c_rdy_full", 64'(c_rdy), 64'h0);
        c_vld = 1'b0;
        // Asynchronous reset between edges
        #1;
        c_rst_n = 1'b0;
        #1;
        chk("c_async_ov", 64'(c_ov), 64'h0);
        chk("c_async_od", 64'(c_od), 64'h0);
        chk("c_async_dc", 64'(c_dc), 64'h0);
        chk("c_async_rdy", 64'(c_rdy), 64'h1);
        tick();
        chk("c_hold_ov", 64'(c_ov), 64'h0);
        c_rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_n_out.md
# demux_n_out

Parametrised 1-to-N demultiplexer with valid/ready handshaking and a one-entry holding register per output channel. It routes each accepted input word to one of N_OUT output channels, either by an explicit select port or by class bits carried in the word. It exerts back-pressure when the target channel is occupied and discards words addressed to non-existent channels, counting them. It sits upstream of the round-robin arbiter, feeding its per-class queues.

## Interface
- DATA_W, 10, width of every data word
- N_OUT, 4, number of output channels (2..16)
- SEL_W, $clog2(N_OUT), width of the destination index
- SEL_FROM_DATA, 0, 0: destination = select port; 1: destination = in_data[DATA_W-1 -: SEL_W]
- DROP_W, 8, width of the dropped-word counter

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while 0
- in_valid  in  1  upstream word present
- in_data  in  DATA_W  upstream word
- select  in  SEL_W  destination index (ignored when SEL_FROM_DATA=1)
- in_ready  out  1  block can accept this cycle
- out_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  N_OUT  channel k holds a word
- out_ready  in  N_OUT  downstream of channel k takes the word this cycle
- drop_count  out  DROP_W  saturating count of words discarded for out-of-range destination

## Operation
- dest = select, or the in_data top SEL_W bits when SEL_FROM_DATA=1; sampled in the same cycle as in_valid.
- A destination is in range when dest < N_OUT. It can only be out of range when N_OUT is not a power of two.
- in_ready is combinational:
  - in range: in_ready = !out_valid[dest] | out_ready[dest]
  - out of range: in_ready = 1
  - in_ready is driven even when in_valid=0.
- Accept = in_valid & in_ready, evaluated at the rising edge.
- Per channel k, each edge:
  - Accept with dest=k: out_data[k] <= in_data, out_valid[k] <= 1. Same-cycle pop plus push is allowed, so a fully streaming channel sustains 1 word/cycle.
  - Else if out_valid[k] & out_ready[k]: out_valid[k] <= 0, and out_data[k] holds its last value.
  - Else: hold.
- Channels are independent. Stalling channel k never blocks a word for channel j≠k.
- Out-of-range accept: the word is discarded, no channel changes, and drop_count increments, saturating at 2^DROP_W-1.
- out_data is stable while out_valid=1 and out_ready=0. A word is never overwritten before it is consumed.
- Asserting reset (0) at any time asynchronously forces:
  - all out_valid = 0
  - all out_data = 0
  - drop_count = 0
- In-flight words are lost on reset. in_ready follows from the cleared state, so it reads 1 during reset.
- Leaving reset (1) takes effect at the next rising edge. No special first-cycle behaviour.

## Timing
- Latency: 1 cycle. A word accepted at edge n is visible on out_data/out_valid after edge n.
- Throughput: 1 word/cycle aggregate when the destination channel is empty or draining.
- Combinational paths: (select or in_data, out_valid, out_ready) -> in_ready. There is no path from in_valid to out_ready.
- drop_count updates at the edge of the discarding accept.
- Reset values of all outputs:
  - out_valid = 0
  - out_data = 0
  - drop_count = 0
  - in_ready = 1

## Test plan
- Reset/basic routing (DATA_W=10, N_OUT=4):
  - Hold reset=0 and confirm out_valid=4'b0000, out_data=0, drop_count=0, in_ready=1.
  - Release reset, then push 10'h155 with select=2 and out_ready=0. Next cycle requires out_valid=4'b0100, out_data[29:20]=10'h155.
- Back-pressure:
  - With channel 2 full and out_ready[2]=0, present a word for select=2. Requires in_ready=0, channel content unchanged.
  - Raise out_ready[2]=1 in the same cycle. Requires in_ready=1 and the new word replaces the old one after the edge, with out_valid[2] staying 1.
- Channel independence: with channel 0 stalled (full, out_ready[0]=0), push words to channels 1 and 3 on consecutive cycles. Both are accepted, and channel 0 holds its word.
- Streaming: with out_ready[1]=1 held, push 8 consecutive words 10'h000..10'h007 to select=1. Requires in_ready=1 every cycle and the outputs appear in order, one per cycle.
- Drop and saturation (N_OUT=3, DROP_W=2): push 5 words with select=3.
  - Requires in_ready=1 for every word and out_valid unchanged.
  - drop_count reads 1, 2, 3, 3, 3.
- Data-class mode and async reset (SEL_FROM_DATA=1, N_OUT=4):
  - Push 10'b11_0000_0001. Requires it to land on channel 3.
  - Then assert reset mid-cycle between edges. Requires out_valid=0, out_data=0 and drop_count=0 immediately, without waiting for a clock edge.
